// File: rtl/deadlock_mon_pkg.sv
// Shared definitions for the per-kernel deadlock monitor: FSM states and
// counter sizing.
package deadlock_mon_pkg;

  localparam int DEFAULT_STALL_CYCLES = 1024;
  localparam int CNT_W                = 16;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    SUSPECT = 2'd1,
    DEAD    = 2'd2
  } mon_state_e;

endpackage

// File: rtl/deadlock_idx0_monitor_stall_timer.sv
// Saturating frozen-stall cycle counter with clear / load-1 / increment
// controls and a terminal-count flag for the deadlock monitor FSM.
module stall_timer
  import deadlock_mon_pkg::*;
#(
  parameter int STALL_CYCLES = DEFAULT_STALL_CYCLES
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic load1,
  input  logic inc,
  output logic tc
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] THRESH  = CNT_W'(STALL_CYCLES);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (load1) begin
      cnt <= CNT_W'(1);
    end else if (inc && (cnt != CNT_MAX)) begin
      cnt <= cnt + 1'b1;
    end
  end

  // cnt holds the number of frozen samples already seen; one further matching
  // sample after THRESH of them declares the deadlock.
  assign tc = (cnt >= THRESH);

endmodule

// File: rtl/deadlock_idx0_monitor.sv
// Per-kernel deadlock detector: raises sticky `block` when the kernel stays
// stalled with a frozen signal pattern. Define DEADLOCK_MON_CAUSE_EN to add
// the `cause` output capturing the frozen pattern.
module deadlock_idx0_monitor
  import deadlock_mon_pkg::*;
#(
  parameter int AXIS_W       = 3,
  parameter int IDLE_W       = 2,
  parameter int INST_W       = 1,
  parameter int STALL_CYCLES = DEFAULT_STALL_CYCLES
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic [AXIS_W-1:0]                 axis_block_sigs,
  input  logic [IDLE_W-1:0]                 inst_idle_sigs,
  input  logic [INST_W-1:0]                 inst_block_sigs,
`ifdef DEADLOCK_MON_CAUSE_EN
  output logic [AXIS_W+IDLE_W+INST_W-1:0]   cause,
`endif
  output logic                              block
);

  localparam int SIG_W = AXIS_W + IDLE_W + INST_W;

  mon_state_e       state, state_d;
  logic [SIG_W-1:0] sig;
  logic [SIG_W-1:0] snapshot;
  logic             stall;
  logic             sig_match;
  logic             t_clr, t_load1, t_inc, t_tc;
  logic             snap_load;
  logic             block_set;

  assign sig       = {axis_block_sigs, inst_idle_sigs, inst_block_sigs};
  assign stall     = (|axis_block_sigs) | (|inst_block_sigs);
  assign sig_match = (sig == snapshot);

  stall_timer #(
    .STALL_CYCLES(STALL_CYCLES)
  ) u_stall_timer (
    .clock (clock),
    .reset (reset),
    .clr   (t_clr),
    .load1 (t_load1),
    .inc   (t_inc),
    .tc    (t_tc)
  );

  // Unknown inputs fall through to the restart branch, so they never count
  // toward a deadlock.
  always_comb begin
    state_d   = state;
    t_clr     = 1'b0;
    t_load1   = 1'b0;
    t_inc     = 1'b0;
    snap_load = 1'b0;
    block_set = 1'b0;
    case (state)
      RUN: begin
        if (stall) begin
          snap_load = 1'b1;
          t_load1   = 1'b1;
          state_d   = SUSPECT;
        end else begin
          t_clr = 1'b1;
        end
      end
      SUSPECT: begin
        if (!stall) begin
          t_clr   = 1'b1;
          state_d = RUN;
        end else if (sig_match) begin
          if (t_tc) begin
            block_set = 1'b1;
            state_d   = DEAD;
          end else begin
            t_inc = 1'b1;
          end
        end else begin
          snap_load = 1'b1;
          t_load1   = 1'b1;
        end
      end
      DEAD: begin
        state_d = DEAD;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  // Registered state, snapshot and sticky flag; reset is the only exit from DEAD.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= RUN;
      snapshot <= '0;
      block    <= 1'b0;
    end else begin
      state <= state_d;
      if (snap_load) begin
        snapshot <= sig;
      end
      if (block_set) begin
        block <= 1'b1;
      end
    end
  end

`ifdef DEADLOCK_MON_CAUSE_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cause <= '0;
    end else if (block_set) begin
      cause <= snapshot;
    end
  end
`endif

endmodule

// File: tb/tb_deadlock_idx0_monitor.sv
// Self-checking bench: five monitors with different thresholds share one
// stimulus stream and are compared against a sample-history reference model.
module tb_deadlock_idx0_monitor;

  localparam int NI = 5;
  localparam int NS [NI] = '{1, 2, 3, 4, 8};

  logic       clock = 1'b0;
  logic       reset;
  logic [2:0] axis;
  logic [1:0] idle;
  logic       inst;
  logic [NI-1:0] block_v;
`ifdef DEADLOCK_MON_CAUSE_EN
  logic [5:0] cause_v [NI];
`endif

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: full sample history since reset, plus per-threshold verdicts.
  logic [5:0] hist [$];
  bit         m_dead  [NI];
  logic [5:0] m_cause [NI];

  always #5 clock = ~clock;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    deadlock_idx0_monitor #(
      .AXIS_W       (3),
      .IDLE_W       (2),
      .INST_W       (1),
      .STALL_CYCLES (NS[g])
    ) u_dut (
      .clock           (clock),
      .reset           (reset),
      .axis_block_sigs (axis),
      .inst_idle_sigs  (idle),
      .inst_block_sigs (inst),
`ifdef DEADLOCK_MON_CAUSE_EN
      .cause           (cause_v[g]),
`endif
      .block           (block_v[g])
    );
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Deadlock iff the latest n+1 samples are all stalled and identical.
  function automatic bit frozen_run(input int n);
    logic [5:0] s;
    logic [5:0] e;
    if (hist.size() < n + 1) return 1'b0;
    s = hist[hist.size()-1];
    for (int i = 0; i <= n; i++) begin
      e = hist[hist.size()-1-i];
      if (e != s) return 1'b0;
      if (!((|e[5:3]) | e[0])) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_clear();
    hist.delete();
    for (int g = 0; g < NI; g++) begin
      m_dead[g]  = 1'b0;
      m_cause[g] = '0;
    end
  endtask

  task automatic model_edge();
    if (reset) begin
      model_clear();
    end else begin
      hist.push_back({axis, idle, inst});
      if (hist.size() > 16) void'(hist.pop_front());
      for (int g = 0; g < NI; g++) begin
        if (!m_dead[g] && frozen_run(NS[g])) begin
          m_dead[g]  = 1'b1;
          m_cause[g] = hist[hist.size()-1];
        end
      end
    end
  endtask

  task automatic check_all();
    for (int g = 0; g < NI; g++) begin
      check_eq($sformatf("block_n%0d", NS[g]), 32'(block_v[g]), 32'(m_dead[g]));
`ifdef DEADLOCK_MON_CAUSE_EN
      check_eq($sformatf("cause_n%0d", NS[g]), 32'(cause_v[g]), 32'(m_cause[g]));
`endif
    end
  endtask

  // Drive inputs (called just after a falling edge), clock once, check.
  task automatic cycle(input logic [2:0] a, input logic [1:0] i, input logic b);
    axis = a;
    idle = i;
    inst = b;
    @(posedge clock);
    model_edge();
    @(negedge clock);
    check_all();
  endtask

  // Asynchronous reset asserted between edges; outputs must clear at once.
  task automatic rst_pulse();
    reset = 1'b1;
    #1;
    model_clear();
    check_all();
    @(posedge clock);
    model_edge();
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    logic [2:0] a;
    logic [1:0] i;
    logic       b;
    int         len;

    reset = 1'b1;
    axis  = 3'b001;
    idle  = 2'b00;
    inst  = 1'b0;
    model_clear();
    @(negedge clock);

    // Reset held with a stall present: nothing may fire.
    for (int k = 0; k < 3; k++) cycle(3'b001, 2'b00, 1'b0);
    reset = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      cycle(3'b001, 2'b00, 1'b0);
      check_eq($sformatf("rst_rel_n4_e%0d", k), 32'(block_v[3]), 32'(k >= 5));
    end

    // Activity restart on an idle-flag toggle.
    rst_pulse();
    for (int k = 0; k < 6; k++) cycle(3'b010, 2'b00, 1'b0);
    for (int k = 1; k <= 10; k++) begin
      cycle(3'b010, 2'b10, 1'b0);
      check_eq($sformatf("restart_n8_e%0d", k), 32'(block_v[4]), 32'(k >= 9));
    end

    // Stall clears just short of the threshold.
    rst_pulse();
    for (int k = 0; k < 7; k++) cycle(3'b100, 2'b00, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      cycle(3'b000, 2'b00, 1'b0);
      check_eq($sformatf("clear_n8_e%0d", k), 32'(block_v[4]), 32'd0);
    end

    // Instance-only stall, then sticky after inputs go quiet.
    rst_pulse();
    for (int k = 1; k <= 3; k++) begin
      cycle(3'b000, 2'b00, 1'b1);
      check_eq($sformatf("inst_n2_e%0d", k), 32'(block_v[1]), 32'(k == 3));
    end
    for (int k = 1; k <= 3; k++) begin
      cycle(3'b000, 2'b00, 1'b0);
      check_eq($sformatf("sticky_n2_e%0d", k), 32'(block_v[1]), 32'd1);
    end

    // Cause capture, then asynchronous reset while blocked.
    rst_pulse();
    for (int k = 1; k <= 4; k++) begin
      cycle(3'b101, 2'b01, 1'b0);
      check_eq($sformatf("cause_blk_n3_e%0d", k), 32'(block_v[2]), 32'(k == 4));
    end
`ifdef DEADLOCK_MON_CAUSE_EN
    check_eq("cause_val_n3", 32'(cause_v[2]), 32'(6'b101010));
`endif
    reset = 1'b1;
    #1;
    check_eq("async_rst_n3", 32'(block_v[2]), 32'd0);
    model_clear();
    @(posedge clock);
    model_edge();
    @(negedge clock);
    reset = 1'b0;
    check_all();

    // Randomized phases of held patterns with occasional activity and resets.
    for (int p = 0; p < 200; p++) begin
      if ($urandom_range(0, 39) == 0) rst_pulse();
      a = 3'($urandom);
      i = 2'($urandom);
      b = 1'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        a = 3'b000;
        b = 1'b0;
      end
      len = $urandom_range(1, 12);
      for (int k = 0; k < len; k++) begin
        if ($urandom_range(0, 9) == 0) i = i ^ 2'($urandom_range(1, 3));
        cycle(a, i, b);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
